uart_rx_sipo_check: RTL and testbench

- Receive datapath directly downstream of the UART RX control FSM.
- It samples `rx` on baud ticks while the FSM holds `sipo_en`, and shifts data bits in LSB-first.
- It pulses `count_bits` back to the FSM after the last data bit, then samples the parity and stop bits.
- On completion it publishes the byte and the error flags, and pulses `pkg_done`; `pkg_done` drives the FSM's `enable_tk_pkg_done`.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync2.sv | 22 ++
 rtl/uart_rx_sipo_check.sv | 159 +++++++++++++++
 tb/tb_uart_rx_sipo_check.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: phase encoding, defaults and parity helper shared
// by the UART RX receive datapath files.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } phase_t;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  // data is zero-extended to the widest legal frame
  function automatic logic parity_calc(
    input logic [8:0] data,
    input logic       odd,
    input logic       par
  );
    return (^data) ^ odd ^ par;
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// uart_rx_sync2: two-flop synchronizer for the serial line,
// resets to the idle (mark) level.
module uart_rx_sync2 (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], d};
    end
  end

  assign q = r_sync[1];

endmodule

// File: rtl/uart_rx_sipo_check.sv
// uart_rx_sipo_check: UART RX shift-in, bit count and frame check.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer.
module uart_rx_sipo_check
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter bit          PARITY_ODD = PAR_EVEN
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx,
  input  logic                 baud_tick,
  input  logic                 sipo_en,
  input  logic                 rx_flag_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 count_bits,
  output logic                 pkg_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  phase_t               r_phase;
  phase_t               w_phase_nxt;
  logic [CW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_par;
  logic                 r_stop;
  logic                 r_count_bits;
  logic                 r_pkg_done;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 w_rx;
  logic                 w_shift_en;
  logic                 w_last;
  logic                 w_par_cap;
  logic                 w_stop_cap;
  logic                 w_perr;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync2 u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (rx),
    .q    (w_rx)
  );
`else
  assign w_rx = rx;
`endif

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_phase <= IDLE;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_shift_en  = 1'b0;
    w_last      = 1'b0;
    w_par_cap   = 1'b0;
    w_stop_cap  = 1'b0;
    unique case (r_phase)
      IDLE: begin
        if (sipo_en && baud_tick) begin
          w_shift_en  = 1'b1;
          w_phase_nxt = DATA;
        end
      end
      DATA: begin
        if (!sipo_en) begin
          w_phase_nxt = IDLE;
        end else if (baud_tick) begin
          w_shift_en = 1'b1;
          if (r_cnt == LAST) begin
            w_last      = 1'b1;
            w_phase_nxt = PARITY;
          end
        end
      end
      PARITY: begin
        if (!sipo_en) begin
          w_phase_nxt = IDLE;
        end else if (baud_tick) begin
          w_par_cap   = 1'b1;
          w_phase_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          w_stop_cap  = 1'b1;
          w_phase_nxt = DONE;
        end
      end
      DONE: begin
        w_phase_nxt = IDLE;
      end
      default: begin
        w_phase_nxt = IDLE;
      end
    endcase
  end

  assign w_perr = parity_calc(9'(r_shift), PARITY_ODD, r_par);

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_stop       <= 1'b0;
      r_rx_data    <= '0;
      r_count_bits <= 1'b0;
      r_pkg_done   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_count_bits <= w_last;
      r_pkg_done   <= (r_phase == DONE);
      if (w_shift_en) begin
        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
      end
      if (w_phase_nxt == IDLE) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_par_cap) begin
        r_par <= w_rx;
      end
      if (w_stop_cap) begin
        r_stop <= w_rx;
      end
      // a fresh frame result beats a same-cycle clear
      if (r_phase == DONE) begin
        r_rx_data    <= r_shift;
        r_parity_err <= w_perr;
        r_frame_err  <= ~r_stop;
      end else if (rx_flag_clr) begin
        r_parity_err <= 1'b0;
        r_frame_err  <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign count_bits = r_count_bits;
  assign pkg_done   = r_pkg_done;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_phase != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo_check.sv
// tb_uart_rx_sipo_check: table frames, hand corner cases and
// random frames checked on even- and odd-parity instances.
module tb_uart_rx_sipo_check;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          rx;
  logic          baud_tick;
  logic          sipo_en;
  logic          rx_flag_clr;
  logic [NB-1:0] e_data, o_data;
  logic          e_cb, e_pd, e_pe, e_fe, e_busy;
  logic          o_cb, o_pd, o_pe, o_fe, o_busy;

  always #5 clk = ~clk;

  uart_rx_sipo_check #(.DATA_BITS(NB), .PARITY_ODD(1'b0)) dut_e (
    .clk         (clk),
    .nrst        (nrst),
    .rx          (rx),
    .baud_tick   (baud_tick),
    .sipo_en     (sipo_en),
    .rx_flag_clr (rx_flag_clr),
    .rx_data     (e_data),
    .count_bits  (e_cb),
    .pkg_done    (e_pd),
    .parity_err  (e_pe),
    .frame_err   (e_fe),
    .busy        (e_busy)
  );

  uart_rx_sipo_check #(.DATA_BITS(NB), .PARITY_ODD(1'b1)) dut_o (
    .clk         (clk),
    .nrst        (nrst),
    .rx          (rx),
    .baud_tick   (baud_tick),
    .sipo_en     (sipo_en),
    .rx_flag_clr (rx_flag_clr),
    .rx_data     (o_data),
    .count_bits  (o_cb),
    .pkg_done    (o_pd),
    .parity_err  (o_pe),
    .frame_err   (o_fe),
    .busy        (o_busy)
  );

  int checks = 0;
  int errors = 0;
  int pd_cnt = 0;
  int cb_cnt = 0;
  int both   = 0;

  typedef struct {
    logic [NB-1:0] d;
    logic          p;
    logic          s;
    logic          clr;
    logic          pe_e;
    logic          pe_o;
    logic          fe;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (e_pd || o_pd) pd_cnt++;
    if (e_cb || o_cb) cb_cnt++;
    if ((e_pd && e_cb) || (o_pd && o_cb)) both++;
  endtask

  task automatic send_bit(input logic b, input logic en);
    rx      = b;
    sipo_en = en;
    repeat (LAT) cyc();
    baud_tick = 1'b1;
    cyc();
    baud_tick = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [NB-1:0] d,
                       input logic p, input logic s,
                       input logic clr, input logic pe_e,
                       input logic pe_o, input logic fe);
    pd_cnt = 0;
    cb_cnt = 0;
    both   = 0;
    for (int i = 0; i < NB; i++) begin
      send_bit(d[i], 1'b1);
    end
    chk({tag, "_cb"}, {e_cb, o_cb}, 2'b11);
    send_bit(p, 1'b1);
    send_bit(s, 1'b0);
    chk({tag, "_done_busy"}, {e_busy, e_pd}, 2'b10);
    rx_flag_clr = clr;
    cyc();
    rx_flag_clr = 1'b0;
    chk({tag, "_pd"}, {e_pd, o_pd, e_busy}, 3'b110);
    chk({tag, "_data_e"}, e_data, d);
    chk({tag, "_data_o"}, o_data, d);
    chk({tag, "_flags_e"}, {e_pe, e_fe}, {pe_e, fe});
    chk({tag, "_flags_o"}, {o_pe, o_fe}, {pe_o, fe});
    cyc();
    chk({tag, "_pulses"}, {pd_cnt[7:0], cb_cnt[7:0], both[7:0]},
        {8'd1, 8'd1, 8'd0});
  endtask

  initial begin
    logic [NB-1:0] rd;
    logic          rp, rs, rc, pe;
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    nrst        = 1'b1;
    rx          = 1'b1;
    baud_tick   = 1'b0;
    sipo_en     = 1'b0;
    rx_flag_clr = 1'b0;
    repeat (3) cyc();
    chk("reset_e", {e_data, e_cb, e_pd, e_pe, e_fe, e_busy}, '0);
    chk("reset_o", {o_data, o_cb, o_pd, o_pe, o_fe, o_busy}, '0);
    nrst = 1'b0;
    cyc();

    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    cyc();
    chk("idle_tick_ignored", {e_busy, o_busy}, 2'b00);

    for (int i = 0; i < 6; i++) begin
      frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].p, tbl[i].s,
            tbl[i].clr, tbl[i].pe_e, tbl[i].pe_o, tbl[i].fe);
      repeat (2) cyc();
    end

    frame("perr", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rx_flag_clr = 1'b1;
    cyc();
    rx_flag_clr = 1'b0;
    chk("clr_flags", {e_pe, e_fe, o_pe, o_fe}, 4'b0000);
    chk("clr_keeps_data", e_data, 8'hA5);

    frame("pre_abort", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_bit(1'($urandom_range(0, 1)), 1'b1);
    end
    chk("abort_pre_busy", {e_busy, o_busy}, 2'b11);
    sipo_en = 1'b0;
    cyc();
    chk("abort_busy", {e_busy, o_busy}, 2'b00);
    repeat (3) cyc();
    chk("abort_no_pd", pd_cnt, 0);
    chk("abort_data", e_data, 8'hA5);
    frame("post_abort", 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    frame("collide", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < NB; i++) begin
      send_bit(i[0], 1'b1);
    end
    nrst = 1'b1;
    cyc();
    nrst = 1'b0;
    chk("midreset_e", {e_data, e_cb, e_pd, e_pe, e_fe, e_busy}, '0);
    chk("midreset_o", {o_data, o_cb, o_pd, o_pe, o_fe, o_busy}, '0);
    repeat (2) cyc();

    for (int k = 0; k < 16; k++) begin
      rd = NB'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 3) != 0);
      rc = 1'($urandom_range(0, 1));
      pe = ((($countones(rd) + int'(rp)) % 2) != 0);
      frame($sformatf("rnd%0d", k), rd, rp, rs, rc, pe, !pe, !rs);
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
